demux_seq: RTL and testbench
============================

# demux_seq

Parametrised sequencer for ADG7xx-family analog multiplexers (ADG732 at default width). It drives the `cs`, `wr`, `ena` and `set_ch` lines with a programmable write-strobe protocol. It steps channels in fixed, sweep-up, sweep-down or ping-pong mode over a configurable channel window, with a programmable dwell per channel. It sits directly behind the tile top level, with its outputs routed to `uo_out`, and supersedes the fixed 32-channel free-running demux.

## Interface
Parameters:
- `CH_BITS`, 5: channel address width; 2^CH_BITS channels.
- `DIV_W`, 24: dwell counter width.
- `CLK_DIVIDER`, 24'd10000000: dwell length in clocks, counted from `cs` rising to the next `cs` falling. Must be ≥1.
- `SETUP_CYC`, 2: clocks with `cs` low and address stable before `wr` falls. Must be ≥1.
- `WR_CYC`, 2: `wr` low width in clocks. Must be ≥1.
- `HOLD_CYC`, 1: clocks `cs` stays low after `wr` rises. Must be ≥1.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `run`  in  1  level; 1 = sequence, 0 = stop after the current transaction.
- `mode`  in  2  00 fixed, 01 sweep up, 10 sweep down, 11 ping-pong.
- `ch_lo`, `ch_hi`  in  CH_BITS  channel window, inclusive.
- `ch_fixed`  in  CH_BITS  channel used in fixed mode.
- `out_en`  in  1  1 = mux switches enabled.
- `ena`  out  1  mux EN, active low.
- `cs`  out  1  chip select, active low.
- `wr`  out  1  write strobe, active low; the device latches on the rising edge.
- `set_ch`  out  CH_BITS  channel address.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `step`  out  1  one-cycle pulse when a write transaction completes.

## Operation
- Reset values: `cs`=1, `wr`=1, `ena`=1, `set_ch`=0, `busy`=0, `step`=0. The FSM enters IDLE, the direction bit is set to up, and the counter is cleared. Reset asserted mid-transaction forces these values immediately, with no clock edge required.
- `ena` is `~out_en`, registered with one clock of latency. It is independent of the FSM.
- FSM states: IDLE, SETUP, STROBE, HOLD, DWELL. All outputs are registered.
  - IDLE: when `run`=1, compute the first channel, load `set_ch`, drive `cs`=0, and go to SETUP. The first channel is `ch_fixed` in mode 00, `lo` in modes 01/11 (direction set to up), and `hi` in mode 10.
  - SETUP: hold for SETUP_CYC clocks, then drive `wr`=0 and go to STROBE.
  - STROBE: hold for WR_CYC clocks, then drive `wr`=1 and go to HOLD.
  - HOLD: hold for HOLD_CYC clocks, then drive `cs`=1, pulse `step`, and go to DWELL.
  - DWELL: count CLK_DIVIDER clocks. At the end, if `run`=0 go to IDLE. Otherwise compute the next channel, load `set_ch`, drive `cs`=0, and go to SETUP.
- `lo`/`hi` are `min(ch_lo,ch_hi)`/`max(ch_lo,ch_hi)`. A swapped window is legal.
- Next-channel rules. `mode`, window and `ch_fixed` are sampled only at the moment the next channel is computed.
  - Fixed: `ch_fixed`. It is rewritten every period, even if unchanged.
  - Sweep up: if `set_ch` ≥ hi → lo, else `set_ch`+1.
  - Sweep down: if `set_ch` ≤ lo → hi, else `set_ch`−1.
  - Ping-pong: step in the current direction. At hi the direction flips to down; at lo it flips to up. If lo == hi, the channel stays put.
  - Any mode: if `set_ch` is outside [lo,hi], the next channel is lo (hi in sweep down).
- Deasserting `run` never truncates SETUP/STROBE/HOLD. If `run`=0 during DWELL, the FSM goes to IDLE immediately at the next edge. `set_ch` retains its last value.
- Address arithmetic is CH_BITS-wide unsigned. It never wraps outside the window.

## Timing
- If `run` is sampled high in IDLE at edge k: `cs`↓ and `set_ch` are valid at k+1, `wr`↓ at k+1+SETUP_CYC, `wr`↑ at k+1+SETUP_CYC+WR_CYC, and `cs`↑ together with `step` at k+1+SETUP_CYC+WR_CYC+HOLD_CYC.
- The channel period is SETUP_CYC+WR_CYC+HOLD_CYC+CLK_DIVIDER clocks.
- `set_ch` changes only on the clock where `cs` falls.
- `busy` rises with `cs`↓ at k+1 and falls on the clock the FSM enters IDLE.

## Structure
- Package `demux_pkg`: `mode_t` enum (FIXED, UP, DOWN, PINGPONG) and `state_t` enum.
- Sub-module `demux_next_ch`: combinational next-channel and next-direction logic, parametrised by CH_BITS.
- One shared DIV_W-bit down-counter serves all timed states.

## Test plan
All scenarios use CH_BITS=3, CLK_DIVIDER=8, SETUP_CYC=2, WR_CYC=2, HOLD_CYC=1.
- Reset, then `run`=1, mode UP, window 2..5: `set_ch` goes 2,3,4,5,2. Each `cs`↓ is exactly 13 clocks after the previous one, and `wr` is low for exactly 2 clocks inside `cs` low.
- Mode DOWN with `ch_lo`=5, `ch_hi`=2 (swapped): `set_ch` goes 5,4,3,2,5.
- Mode PINGPONG, window 1..3: `set_ch` goes 1,2,3,2,1,2. With window 4..4: `set_ch` stays 4 and `step` keeps pulsing.
- Drop `run` during STROBE: `wr`↑ and `cs`↑ still occur on schedule, the FSM enters IDLE after at most 1 DWELL clock, and `busy`=0 with `set_ch` unchanged.
- Assert `rst` while `wr`=0: `wr`, `cs` and `ena` read 1 and `set_ch` reads 0 before the next clock edge. After release, the FSM stays IDLE until `run` is sampled high.
- Mode FIXED with `ch_fixed`=6, then change it to 1 mid-dwell: the next write carries 1. Toggling `out_en` changes `ena` one clock later regardless of FSM state.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the ADG7xx demux sequencer: channel-step modes and FSM states.
package demux_pkg;

  typedef enum logic [1:0] {
    FIXED    = 2'd0,
    UP       = 2'd1,
    DOWN     = 2'd2,
    PINGPONG = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DWELL  = 3'd4
  } state_t;

endpackage

// File: rtl/demux_next_ch.sv
// Combinational next-channel / next-direction selection for the demux sequencer.
module demux_next_ch
  import demux_pkg::*;
#(
  parameter int unsigned CH_BITS = 5
) (
  input  logic               first,
  input  logic [1:0]         mode,
  input  logic [CH_BITS-1:0] ch_lo,
  input  logic [CH_BITS-1:0] ch_hi,
  input  logic [CH_BITS-1:0] ch_fixed,
  input  logic [CH_BITS-1:0] cur,
  input  logic               dir_up,
  output logic [CH_BITS-1:0] nxt,
  output logic               nxt_dir_up
);

  mode_t              m;
  logic [CH_BITS-1:0] lo;
  logic [CH_BITS-1:0] hi;

  always_comb begin
    m          = mode_t'(mode);
    lo         = (ch_lo <= ch_hi) ? ch_lo : ch_hi;
    hi         = (ch_lo <= ch_hi) ? ch_hi : ch_lo;
    nxt        = cur;
    nxt_dir_up = dir_up;

    if (first) begin
      case (m)
        FIXED:   nxt = ch_fixed;
        DOWN:    nxt = hi;
        default: begin
          nxt        = lo;
          nxt_dir_up = 1'b1;
        end
      endcase
    end else if (m == FIXED) begin
      nxt = ch_fixed;
    end else if ((cur < lo) || (cur > hi)) begin
      // Re-enter the window at its natural starting edge.
      if (m == DOWN) begin
        nxt = hi;
      end else begin
        nxt        = lo;
        nxt_dir_up = 1'b1;
      end
    end else begin
      case (m)
        UP:   nxt = (cur >= hi) ? lo : CH_BITS'(cur + 1'b1);
        DOWN: nxt = (cur <= lo) ? hi : CH_BITS'(cur - 1'b1);
        default: begin
          if (lo == hi) begin
            nxt = lo;
          end else if (dir_up) begin
            if (cur >= hi) begin
              nxt        = CH_BITS'(cur - 1'b1);
              nxt_dir_up = 1'b0;
            end else begin
              nxt = CH_BITS'(cur + 1'b1);
            end
          end else begin
            if (cur <= lo) begin
              nxt        = CH_BITS'(cur + 1'b1);
              nxt_dir_up = 1'b1;
            end else begin
              nxt = CH_BITS'(cur - 1'b1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/demux_seq.sv
// ADG7xx analog-mux sequencer: write-strobe protocol on cs/wr/set_ch with a
// programmable per-channel dwell and fixed/sweep/ping-pong channel stepping.
module demux_seq
  import demux_pkg::*;
#(
  parameter int unsigned CH_BITS     = 5,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned CLK_DIVIDER = 10000000,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned WR_CYC      = 2,
  parameter int unsigned HOLD_CYC    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [CH_BITS-1:0] ch_lo,
  input  logic [CH_BITS-1:0] ch_hi,
  input  logic [CH_BITS-1:0] ch_fixed,
  input  logic               out_en,
  output logic               ena,
  output logic               cs,
  output logic               wr,
  output logic [CH_BITS-1:0] set_ch,
  output logic               busy,
  output logic               step
);

  localparam logic [DIV_W-1:0] SETUP_LD = DIV_W'(SETUP_CYC - 1);
  localparam logic [DIV_W-1:0] WR_LD    = DIV_W'(WR_CYC - 1);
  localparam logic [DIV_W-1:0] HOLD_LD  = DIV_W'(HOLD_CYC - 1);
  localparam logic [DIV_W-1:0] DWELL_LD = DIV_W'(CLK_DIVIDER - 1);

  state_t             state;
  logic [DIV_W-1:0]   cnt;
  logic               dir_up;
  logic               first;
  logic [CH_BITS-1:0] nxt_ch;
  logic               nxt_dir_up;

  assign first = (state == IDLE);

  demux_next_ch #(
    .CH_BITS (CH_BITS)
  ) u_next_ch (
    .first      (first),
    .mode       (mode),
    .ch_lo      (ch_lo),
    .ch_hi      (ch_hi),
    .ch_fixed   (ch_fixed),
    .cur        (set_ch),
    .dir_up     (dir_up),
    .nxt        (nxt_ch),
    .nxt_dir_up (nxt_dir_up)
  );

  // Enable line follows out_en with one register of latency, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ena <= 1'b1;
    else     ena <= ~out_en;
  end

  // Transaction FSM; one shared down-counter times every non-idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dir_up <= 1'b1;
      cs     <= 1'b1;
      wr     <= 1'b1;
      set_ch <= '0;
      busy   <= 1'b0;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            set_ch <= nxt_ch;
            dir_up <= nxt_dir_up;
            cs     <= 1'b0;
            busy   <= 1'b1;
            cnt    <= SETUP_LD;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            wr    <= 1'b0;
            cnt   <= WR_LD;
            state <= STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            wr    <= 1'b1;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cs    <= 1'b1;
            step  <= 1'b1;
            cnt   <= DWELL_LD;
            state <= DWELL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DWELL: begin
          if (!run) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == '0) begin
            set_ch <= nxt_ch;
            dir_up <= nxt_dir_up;
            cs     <= 1'b0;
            cnt    <= SETUP_LD;
            state  <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          cs    <= 1'b1;
          wr    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_seq.sv
// Directed self-checking bench for demux_seq at CH_BITS=3, dwell 8, setup 2, strobe 2, hold 1.
module tb_demux_seq;

  logic       clk;
  logic       rst;
  logic       run;
  logic [1:0] mode;
  logic [2:0] ch_lo;
  logic [2:0] ch_hi;
  logic [2:0] ch_fixed;
  logic       out_en;
  logic       ena;
  logic       cs;
  logic       wr;
  logic [2:0] set_ch;
  logic       busy;
  logic       step;

  int tests;
  int fails;

  demux_seq #(
    .CH_BITS     (3),
    .DIV_W       (24),
    .CLK_DIVIDER (8),
    .SETUP_CYC   (2),
    .WR_CYC      (2),
    .HOLD_CYC    (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .mode     (mode),
    .ch_lo    (ch_lo),
    .ch_hi    (ch_hi),
    .ch_fixed (ch_fixed),
    .out_en   (out_en),
    .ena      (ena),
    .cs       (cs),
    .wr       (wr),
    .set_ch   (set_ch),
    .busy     (busy),
    .step     (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cs falling edge (sampled 1 time unit after each clock).
  task automatic wait_fall(output bit ok, output int cyc, output int steps);
    logic prev;
    prev  = cs;
    ok    = 1'b0;
    cyc   = 0;
    steps = 0;
    while (!ok && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (step) steps++;
      if (prev && !cs) ok = 1'b1;
      prev = cs;
    end
  endtask

  task automatic go_idle(output bit ok);
    int n;
    run = 1'b0;
    n   = 0;
    ok  = 1'b0;
    while (!ok && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; mode = 2'd0; ch_lo = 3'd0; ch_hi = 3'd0;
    ch_fixed = 3'd0; out_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (cs !== 1'b1) begin fails++; $display("FAIL reset_cs got %b want 1", cs); end
    tests++; if (wr !== 1'b1) begin fails++; $display("FAIL reset_wr got %b want 1", wr); end
    tests++; if (ena !== 1'b1) begin fails++; $display("FAIL reset_ena got %b want 1", ena); end
    tests++; if (set_ch !== 3'd0) begin fails++; $display("FAIL reset_set_ch got %0d want 0", set_ch); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (step !== 1'b0) begin fails++; $display("FAIL reset_step got %b want 0", step); end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests++; if (busy !== 1'b0 || cs !== 1'b1) begin fails++; $display("FAIL idle_after_reset got busy=%b cs=%b want busy=0 cs=1", busy, cs); end
  endtask

  task automatic test_sweep_up;
    logic [2:0] exp_ch [5];
    bit ok; int cyc; int st;
    int fall_at; int wlow; int wbad; int nstep; logic prev;
    exp_ch = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd2};
    mode = 2'd1; ch_lo = 3'd2; ch_hi = 3'd5; run = 1'b1;
    wait_fall(ok, cyc, st);
    tests++; if (!ok || cyc !== 1) begin fails++; $display("FAIL up_first_fall got ok=%b cyc=%0d want ok=1 cyc=1", ok, cyc); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL up_busy got %b want 1", busy); end
    tests++; if (set_ch !== exp_ch[0]) begin fails++; $display("FAIL up_ch0 got %0d want %0d", set_ch, exp_ch[0]); end
    for (int p = 1; p < 5; p++) begin
      fall_at = 0; wlow = 0; wbad = 0; nstep = 0; prev = cs;
      for (int c = 1; c <= 13; c++) begin
        @(posedge clk); #1;
        if (!wr) begin wlow++; if (cs) wbad++; end
        if (step) nstep++;
        if (prev && !cs && fall_at == 0) fall_at = c;
        prev = cs;
      end
      tests++; if (fall_at !== 13) begin fails++; $display("FAIL up_period[%0d] got %0d want 13", p, fall_at); end
      tests++; if (wlow !== 2 || wbad !== 0) begin fails++; $display("FAIL up_wr_low[%0d] got low=%0d outside_cs=%0d want 2/0", p, wlow, wbad); end
      tests++; if (nstep !== 1) begin fails++; $display("FAIL up_step[%0d] got %0d want 1", p, nstep); end
      tests++; if (set_ch !== exp_ch[p]) begin fails++; $display("FAIL up_ch[%0d] got %0d want %0d", p, set_ch, exp_ch[p]); end
    end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL up_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_sweep_down;
    logic [2:0] exp_ch [5];
    bit ok; int cyc; int st;
    exp_ch = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd5};
    mode = 2'd2; ch_lo = 3'd5; ch_hi = 3'd2; run = 1'b1;
    for (int p = 0; p < 5; p++) begin
      wait_fall(ok, cyc, st);
      tests++; if (!ok || set_ch !== exp_ch[p]) begin fails++; $display("FAIL down_ch[%0d] got %0d (ok=%b) want %0d", p, set_ch, ok, exp_ch[p]); end
    end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL down_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_pingpong;
    logic [2:0] exp_ch [6];
    bit ok; int cyc; int st;
    exp_ch = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2};
    mode = 2'd3; ch_lo = 3'd1; ch_hi = 3'd3; run = 1'b1;
    for (int p = 0; p < 6; p++) begin
      wait_fall(ok, cyc, st);
      tests++; if (!ok || set_ch !== exp_ch[p]) begin fails++; $display("FAIL pp_ch[%0d] got %0d (ok=%b) want %0d", p, set_ch, ok, exp_ch[p]); end
    end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL pp_idle got busy=%b want 0", busy); end
    ch_lo = 3'd4; ch_hi = 3'd4; run = 1'b1;
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd4) begin fails++; $display("FAIL pp_single_first got %0d want 4", set_ch); end
    for (int p = 1; p < 4; p++) begin
      wait_fall(ok, cyc, st);
      tests++; if (!ok || set_ch !== 3'd4 || st !== 1 || cyc !== 13) begin
        fails++; $display("FAIL pp_single[%0d] got ch=%0d steps=%0d cyc=%0d want 4/1/13", p, set_ch, st, cyc);
      end
    end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL pp_single_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_drop_run;
    bit ok; int cyc; int st;
    mode = 2'd1; ch_lo = 3'd0; ch_hi = 3'd7; run = 1'b1;
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd0) begin fails++; $display("FAIL drop_first got %0d want 0", set_ch); end
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL drop_in_strobe got wr=%b want 0", wr); end
    run = 1'b0;
    @(posedge clk); #1;
    tests++; if (wr !== 1'b0 || cs !== 1'b0) begin fails++; $display("FAIL drop_c3 got wr=%b cs=%b want 0/0", wr, cs); end
    @(posedge clk); #1;
    tests++; if (wr !== 1'b1 || cs !== 1'b0) begin fails++; $display("FAIL drop_c4 got wr=%b cs=%b want 1/0", wr, cs); end
    @(posedge clk); #1;
    tests++; if (cs !== 1'b1 || step !== 1'b1) begin fails++; $display("FAIL drop_c5 got cs=%b step=%b want 1/1", cs, step); end
    @(posedge clk); #1;
    tests++; if (busy !== 1'b0 || set_ch !== 3'd0) begin fails++; $display("FAIL drop_idle got busy=%b ch=%0d want 0/0", busy, set_ch); end
    repeat (15) begin @(posedge clk); #1; end
    tests++; if (cs !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL drop_stays_idle got cs=%b busy=%b want 1/0", cs, busy); end
  endtask

  task automatic test_reset_mid;
    bit ok; int cyc; int st;
    mode = 2'd1; ch_lo = 3'd3; ch_hi = 3'd6; out_en = 1'b1; run = 1'b1;
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd3 || ena !== 1'b0) begin fails++; $display("FAIL rmid_pre got ch=%0d ena=%b want 3/0", set_ch, ena); end
    repeat (2) begin @(posedge clk); #1; end
    tests++; if (wr !== 1'b0) begin fails++; $display("FAIL rmid_wr_low got %b want 0", wr); end
    rst = 1'b1; run = 1'b0;
    #1;
    tests++; if (wr !== 1'b1 || cs !== 1'b1 || ena !== 1'b1 || set_ch !== 3'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL rmid_async got wr=%b cs=%b ena=%b ch=%0d busy=%b want 1/1/1/0/0", wr, cs, ena, set_ch, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tests++; if (busy !== 1'b0 || cs !== 1'b1 || ena !== 1'b0) begin fails++; $display("FAIL rmid_idle got busy=%b cs=%b ena=%b want 0/1/0", busy, cs, ena); end
    run = 1'b1;
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1 || cs !== 1'b0 || set_ch !== 3'd3) begin fails++; $display("FAIL rmid_restart got busy=%b cs=%b ch=%0d want 1/0/3", busy, cs, set_ch); end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rmid_end got busy=%b want 0", busy); end
    out_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_and_en;
    bit ok; int cyc; int st;
    mode = 2'd0; ch_lo = 3'd0; ch_hi = 3'd7; ch_fixed = 3'd6; run = 1'b1;
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd6) begin fails++; $display("FAIL fixed_first got %0d want 6", set_ch); end
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd6 || cyc !== 13) begin fails++; $display("FAIL fixed_repeat got ch=%0d cyc=%0d want 6/13", set_ch, cyc); end
    repeat (7) begin @(posedge clk); #1; end
    ch_fixed = 3'd1;
    tests++; if (cs !== 1'b1 || set_ch !== 3'd6) begin fails++; $display("FAIL fixed_mid_dwell got cs=%b ch=%0d want 1/6", cs, set_ch); end
    out_en = 1'b1;
    @(posedge clk); #1;
    tests++; if (ena !== 1'b0) begin fails++; $display("FAIL ena_busy got %b want 0", ena); end
    wait_fall(ok, cyc, st);
    tests++; if (!ok || set_ch !== 3'd1) begin fails++; $display("FAIL fixed_change got %0d want 1", set_ch); end
    go_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL fixed_idle got busy=%b want 0", busy); end
    out_en = 1'b0;
    tests++; if (ena !== 1'b0) begin fails++; $display("FAIL ena_latency got %b want 0", ena); end
    @(posedge clk); #1;
    tests++; if (ena !== 1'b1) begin fails++; $display("FAIL ena_idle got %b want 1", ena); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset;
    test_sweep_up;
    test_sweep_down;
    test_pingpong;
    test_drop_run;
    test_reset_mid;
    test_fixed_and_en;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
